// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared state encodings and BCD field limits for the timekeeper
package clock_pkg;
  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_SET_HR  = 2'b01;
  localparam logic [1:0] ST_SET_MIN = 2'b10;

  localparam int SEC_MAX   = 59;
  localparam int MIN_MAX   = 59;
  localparam int HR_MAX_24 = 23;
  localparam int HR_MAX_12 = 12;
endpackage

// File: rtl/clock_timekeeper_if.sv
// rtl/clock_timekeeper_if.sv - control inputs and display-side outputs of the timekeeper
interface clock_timekeeper_if;
  logic       run;
  logic       mode_btn;
  logic       inc_btn;
  logic [3:0] h1;
  logic [3:0] h2;
  logic [3:0] m1;
  logic [3:0] m2;
  logic [3:0] s1;
  logic [3:0] s2;
  logic [1:0] set_mode;
  logic       tick;
  logic       pm;

  modport master (
    input  run, mode_btn, inc_btn,
    output h1, h2, m1, m2, s1, s2, set_mode, tick, pm
  );

  modport slave (
    output run, mode_btn, inc_btn,
    input  h1, h2, m1, m2, s1, s2, set_mode, tick, pm
  );
endinterface

// File: rtl/bcd2_counter.sv
// rtl/bcd2_counter.sv - two-digit BCD counter wrapping from MAX back to MIN
module bcd2_counter #(
  parameter int MAX = 59,
  parameter int MIN = 0,
  parameter int RST = 0
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       inc,
  input  logic       load_zero,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       carry
);
  localparam logic [3:0] MAX_T = 4'(MAX / 10);
  localparam logic [3:0] MAX_U = 4'(MAX % 10);
  localparam logic [3:0] MIN_T = 4'(MIN / 10);
  localparam logic [3:0] MIN_U = 4'(MIN % 10);
  localparam logic [3:0] RST_T = 4'(RST / 10);
  localparam logic [3:0] RST_U = 4'(RST % 10);

  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic       at_max;

  assign at_max = (tens_q == MAX_T) && (units_q == MAX_U);
  assign carry  = inc && at_max;

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (load_zero) begin
      tens_d  = 4'd0;
      units_d = 4'd0;
    end else if (inc) begin
      if (at_max) begin
        tens_d  = MIN_T;
        units_d = MIN_U;
      end else if (units_q == 4'd9) begin
        tens_d  = tens_q + 4'd1;
        units_d = 4'd0;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tens_q  <= RST_T;
      units_q <= RST_U;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens  = tens_q;
  assign units = units_q;
endmodule

// File: rtl/clock_timekeeper.sv
// rtl/clock_timekeeper.sv - 1 Hz prescaler, BCD hh:mm:ss keeping and button set mode
// CLOCK_12H_EN selects the 12-hour display with PM indicator.
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int CNT_W    = 27
) (
  input  logic                 clk,
  input  logic                 clr_n,
  clock_timekeeper_if.master   disp
);
`ifdef CLOCK_12H_EN
  localparam int HR_MAX = HR_MAX_12;
  localparam int HR_MIN = 1;
  localparam int HR_RST = 12;
`else
  localparam int HR_MAX = HR_MAX_24;
  localparam int HR_MIN = 0;
  localparam int HR_RST = 0;
`endif
  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             tick_q;
  logic             advance, tick_fire, set_hr_inc, set_min_inc, hr_tick_inc;
  logic             sec_carry, min_carry, unused_hr_carry;
  logic [3:0]       s_t, s_u, m_t, m_u, h_t, h_u;

  // A mode press on the wrap edge discards that tick; inc alongside mode is dropped.
  assign advance     = disp.run && (state_q == ST_RUN);
  assign tick_fire   = advance && (presc_q == PRESC_LAST) && !disp.mode_btn;
  assign set_hr_inc  = (state_q == ST_SET_HR)  && disp.inc_btn && !disp.mode_btn;
  assign set_min_inc = (state_q == ST_SET_MIN) && disp.inc_btn && !disp.mode_btn;
  assign hr_tick_inc = tick_fire && min_carry;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (disp.mode_btn) state_d = ST_SET_HR;
      ST_SET_HR:  if (disp.mode_btn) state_d = ST_SET_MIN;
      ST_SET_MIN: if (disp.mode_btn) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_comb begin
    presc_d = presc_q;
    if (state_d != ST_RUN) begin
      presc_d = '0;
    end else if (advance) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_RUN;
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_fire;
    end
  end

  bcd2_counter #(.MAX(SEC_MAX), .MIN(0), .RST(0)) u_sec (
    .clk(clk), .clr_n(clr_n), .inc(tick_fire), .load_zero(state_d != ST_RUN),
    .tens(s_t), .units(s_u), .carry(sec_carry)
  );

  bcd2_counter #(.MAX(MIN_MAX), .MIN(0), .RST(0)) u_min (
    .clk(clk), .clr_n(clr_n), .inc(sec_carry || set_min_inc), .load_zero(1'b0),
    .tens(m_t), .units(m_u), .carry(min_carry)
  );

  bcd2_counter #(.MAX(HR_MAX), .MIN(HR_MIN), .RST(HR_RST)) u_hr (
    .clk(clk), .clr_n(clr_n), .inc(hr_tick_inc || set_hr_inc), .load_zero(1'b0),
    .tens(h_t), .units(h_u), .carry(unused_hr_carry)
  );

`ifdef CLOCK_12H_EN
  logic pm_q;

  // PM flips on the 11 -> 12 rollover from time keeping, never from the set path.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pm_q <= 1'b0;
    end else if (hr_tick_inc && (h_t == 4'd1) && (h_u == 4'd1)) begin
      pm_q <= ~pm_q;
    end
  end
  assign disp.pm = pm_q;
`else
  assign disp.pm = 1'b0;
`endif

  assign disp.h1       = h_t;
  assign disp.h2       = h_u;
  assign disp.m1       = m_t;
  assign disp.m2       = m_u;
  assign disp.s1       = s_t;
  assign disp.s2       = s_u;
  assign disp.set_mode = state_q;
  assign disp.tick     = tick_q;
endmodule

// File: tb/tb_clock_timekeeper.sv
// tb/tb_clock_timekeeper.sv - directed self-checking bench for clock_timekeeper at TICK_DIV=4
module tb_clock_timekeeper;
  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 3;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  clock_timekeeper_if bus ();

  clock_timekeeper #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr_n(clr_n), .disp(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] now();
    return {8'h00, bus.h1, bus.h2, bus.m1, bus.m2, bus.s1, bus.s2};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    bus.mode_btn = 1'b1;
    step(1);
    bus.mode_btn = 1'b0;
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      bus.inc_btn = 1'b1;
      step(1);
      bus.inc_btn = 1'b0;
    end
  endtask

  task automatic count_ticks(input int n, output int ticks);
    ticks = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (bus.tick) ticks++;
    end
  endtask

  task automatic find_tick(output int idx);
    idx = -1;
    for (int c = 1; c <= 10; c++) begin
      step(1);
      if (bus.tick && idx < 0) idx = c;
      if (idx >= 0) break;
    end
  endtask

  initial begin
    int ticks;
    int last;
    int gap_bad;
    int idx;

    bus.run      = 1'b1;
    bus.mode_btn = 1'b0;
    bus.inc_btn  = 1'b0;
    #2;
`ifdef CLOCK_12H_EN
    check("rst12_time", now(), 32'h120000);
    check("rst12_pm", 32'(bus.pm), 32'h0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    press_mode();
    press_inc(11);
    check("set12_hr", now(), 32'h110000);
    press_mode();
    press_inc(59);
    press_mode();
    check("set12_min", now(), 32'h115900);
    step(236);
    check("pre_noon", now(), 32'h115959);
    check("pre_noon_pm", 32'(bus.pm), 32'h0);
    step(4);
    check("noon", now(), 32'h120000);
    check("noon_pm", 32'(bus.pm), 32'h1);
    clr_n = 1'b0;
    #2;
    check("rst12b_time", now(), 32'h120000);
    check("rst12b_pm", 32'(bus.pm), 32'h0);
`else
    check("rst_time", now(), 32'h000000);
    check("rst_tick", 32'(bus.tick), 32'h0);
    check("rst_mode", 32'(bus.set_mode), 32'h0);
    check("rst_pm", 32'(bus.pm), 32'h0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;

    ticks = 0; last = 0; gap_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      step(1);
      if (bus.tick) begin
        if (c - last != 4) gap_bad++;
        last = c;
        ticks++;
      end
    end
    check("t1_ticks", ticks, 10);
    check("t1_gaps", gap_bad, 0);
    check("t1_time", now(), 32'h000010);

    step(196);
    check("t2_sec59", now(), 32'h000059);
    step(4);
    check("t2_carry_min", now(), 32'h000100);
    press_mode();
    press_inc(23);
    press_mode();
    press_inc(58);
    press_mode();
    check("t2_set", now(), 32'h235900);
    step(236);
    check("t2_235959", now(), 32'h235959);
    step(4);
    check("t2_midnight", now(), 32'h000000);
    check("t2_midnight_tick", 32'(bus.tick), 32'h1);

    step(12);
    check("t3_run3", now(), 32'h000003);
    press_inc(1);
    check("t3_inc_run_ign", now(), 32'h000003);
    press_mode();
    check("t3_mode_hr", 32'(bus.set_mode), 32'h1);
    check("t3_sec_zero", now(), 32'h000000);
    count_ticks(20, ticks);
    check("t3_no_ticks", ticks, 0);
    press_inc(25);
    check("t3_hr_wrap", now(), 32'h010000);

    press_mode();
    check("t4_mode_min", 32'(bus.set_mode), 32'h2);
    press_inc(59);
    check("t4_min59", now(), 32'h015900);
    press_inc(1);
    check("t4_min_wrap", now(), 32'h010000);
    press_mode();
    check("t4_mode_run", 32'(bus.set_mode), 32'h0);
    find_tick(idx);
    check("t4_first_tick", idx, 4);
    check("t4_time", now(), 32'h010001);

    step(3);
    press_mode();
    check("t5_tick_drop", 32'(bus.tick), 32'h0);
    check("t5_mode_hr", 32'(bus.set_mode), 32'h1);
    check("t5_time", now(), 32'h010000);
    bus.mode_btn = 1'b1;
    bus.inc_btn  = 1'b1;
    step(1);
    bus.mode_btn = 1'b0;
    bus.inc_btn  = 1'b0;
    check("t5_mode_inc", 32'(bus.set_mode), 32'h2);
    check("t5_mode_inc_time", now(), 32'h010000);
    press_inc(5);
    check("t5_min5", now(), 32'h010500);
    clr_n = 1'b0;
    #2;
    check("t5_async_time", now(), 32'h000000);
    check("t5_async_mode", 32'(bus.set_mode), 32'h0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;

    bus.run = 1'b0;
    count_ticks(12, ticks);
    check("hold_ticks", ticks, 0);
    check("hold_time", now(), 32'h000000);
    bus.run = 1'b1;
    find_tick(idx);
    check("resume_tick", idx, 4);
    check("resume_time", now(), 32'h000001);
    check("pm_24h", 32'(bus.pm), 32'h0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/clock_timekeeper.md
Name: clock_timekeeper

Overview:
- Upstream stage of the seven-segment display driver in the FPGA digital clock.
- Divides the board clock down to a 1 Hz tick and keeps time as six BCD digits: hours, minutes, seconds.
- Provides a button-driven set mode for hours and minutes.
- The digit outputs connect directly to the display driver's h1,h2,m1,m2,s1,s2 inputs.

Parameters:
- TICK_DIV, 100000000, board clock cycles per 1 s tick; the minimum legal value is 2.
- CNT_W, 27, prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk  in  1  board clock; all logic is on its rising edge.
- clr_n  in  1  asynchronous active-low reset.
- run  in  1  1 = time advances; 0 = prescaler and digits frozen.
- mode_btn  in  1  single-cycle pulse, already synchronised and debounced upstream; cycles the set state.
- inc_btn  in  1  single-cycle pulse; increments the field currently being set.
- h1  out  4  hours tens digit, BCD.
- h2  out  4  hours units digit, BCD.
- m1  out  4  minutes tens digit, BCD.
- m2  out  4  minutes units digit, BCD.
- s1  out  4  seconds tens digit, BCD.
- s2  out  4  seconds units digit, BCD.
- set_mode  out  2  00 RUN, 01 SET_HR, 10 SET_MIN; used for blink or indication.
- tick  out  1  one-cycle pulse on each 1 s tick.
- pm  out  1  PM indicator; only meaningful with the optional feature.

Behaviour:
- Reset (clr_n low, asynchronous):
  - All digits 0, i.e. 00:00:00.
  - Prescaler 0, tick 0, state RUN, set_mode 00, pm 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while run=1 and state=RUN, then wraps to 0.
  - tick is registered; it is high for the one cycle after the prescaler reaches TICK_DIV-1.
- Digit update:
  - Digits update on the same edge that asserts tick, so registered outputs show the new time together with tick high.
  - Latency: tick and digit change are exactly TICK_DIV cycles after the prescaler was at 0.
- Counting rules:
  - s2 0..9 carries into s1; s1 0..5 carries into m2.
  - m2 0..9 carries into m1; m1 0..5 carries into hours.
  - Hours count 00..23; 23:59:59 goes to 00:00:00 on the next tick.
  - Digits never hold a non-BCD value or a value above their field maximum.
- State machine (mode_btn pulse advances it):
  - RUN -> SET_HR -> SET_MIN -> RUN.
- In SET_HR and SET_MIN:
  - Prescaler is held at 0 and seconds are forced to 00 on entry.
  - No ticks are generated.
  - inc_btn adds 1 to the selected field with wrap and no carry: hours 23->00, minutes 59->00.
- Leaving SET_MIN for RUN: prescaler restarts from 0, so the first tick arrives a full TICK_DIV cycles later.
- inc_btn in RUN is ignored.
- Simultaneous events:
  - mode_btn together with a tick: the mode change wins and the tick is discarded.
  - mode_btn together with inc_btn: the mode change is applied and inc is ignored.
- run=0: everything holds, including the prescaler. Mode and inc still work.
- clr_n asserted mid-set: the block returns to RUN at 00:00:00 immediately.

Optional Feature:
- Macro CLOCK_12H_EN.
- Defined:
  - Hours run 12,01..11; 11:59:59 -> 12:00:00 toggles pm.
  - Reset value is 12:00:00 with pm=0.
  - Setting hours wraps 12->01 and does not change pm.
- Undefined: 24-hour behaviour as above, with pm tied to 0.

Decomposition:
- Shared package clock_pkg holds:
  - State encodings ST_RUN, ST_SET_HR, ST_SET_MIN.
  - BCD field limits SEC_MAX=59, MIN_MAX=59, HR_MAX_24=23, HR_MAX_12=12.
- One sub-module, bcd2_counter: a two-digit BCD counter.
  - Parameter MAX; inputs clk, clr_n, inc, load-zero.
  - Outputs tens, units, carry (high when wrapping at MAX).
  - Instantiated for seconds and minutes; hours use a dedicated instance because of the 12-hour variant.

Test Plan (run with TICK_DIV=4):
1. Reset release, run=1, 40 cycles -> exactly 10 tick pulses, 4 cycles apart; digits read 00:00:10.
2. Force 00:00:59 via set path plus ticks, then one tick -> 00:01:00; from 23:59:59, one tick -> 00:00:00.
3. mode_btn once -> set_mode=01, seconds=00, no ticks for 20 cycles; inc_btn x25 from 00 -> hours=01 (23->00 wrap then +1); minutes unchanged.
4. SET_MIN at 59, inc_btn -> minutes 00, hours unchanged; mode_btn -> RUN, first tick exactly 4 cycles later.
5. mode_btn in the same cycle as a tick -> state SET_HR, seconds 00, no increment; clr_n pulsed low mid-SET_MIN -> 00:00:00, RUN, asynchronously.
6. With CLOCK_12H_EN, from 11:59:59 pm=0, one tick -> 12:00:00 pm=1; reset -> 12:00:00 pm=0.
